// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div : iterative RV32M divider (DIV, DIVU, REM, REMU)
//
// Radix-2 restoring divider producing one quotient bit per clock. Only one
// operation is in flight at a time. The result leaves as a writeback pulse that
// carries the destination register, the instruction tag and the instruction
// word.
//
// Ports
//   clk            in   core clock
//   rstn           in   synchronous active-low reset
//   freeze         in   pipeline freeze, holds every register while high
//   div_ctrl       in   decode bundle (legal, div, rem, unsign, rs1_data,
//                       rs2_data, rd_addr, instr_tag, instr)
//   out            out  quotient or remainder
//   out_rd_addr    out  destination register of the completing op
//   out_rd_wr_en   out  writeback strobe, high in the DONE state only
//   instr_tag_out  out  tag of the completing op
//   instr_out      out  instruction word of the completing op
//   div_busy       out  high in CALC and FIX; upstream must not issue then
//   dbg_state_o    out  current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
// Handshake: an op is accepted in any cycle where div_ctrl.legal and
// div_ctrl.div are high, freeze is low and div_busy is low. No ready/stall
// is returned; an op offered while div_busy is high is dropped. The result is
// valid exactly while out_rd_wr_en is high.
//
// Optional feature (macro DIV_EARLY_OUT_EN): a zero divisor or the signed
// overflow case is recognised at accept time. The op then runs a single CALC
// cycle and writes back three cycles after issue instead of XLEN+2.
//
// XLEN normally comes from global.svh; a 32-bit fallback is provided here.
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

`ifndef IDU1_OUT_T_DEFINED
`define IDU1_OUT_T_DEFINED
typedef struct packed {
   logic              legal;
   logic              div;
   logic              rem;
   logic              unsign;
   logic [`XLEN-1:0]  rs1_data;
   logic [`XLEN-1:0]  rs2_data;
   logic [4:0]        rd_addr;
   logic [`XLEN-1:0]  instr_tag;
   logic [31:0]       instr;
} idu1_out_t;
`endif

module div (
   input  logic              clk,
   input  logic              rstn,
   input  logic              freeze,
   input  idu1_out_t         div_ctrl,
   output logic [`XLEN-1:0]  out,
   output logic [4:0]        out_rd_addr,
   output logic              out_rd_wr_en,
   output logic [`XLEN-1:0]  instr_tag_out,
   output logic [31:0]       instr_out,
   output logic              div_busy,
   output logic [1:0]        dbg_state_o
);

   localparam int XLEN = `XLEN;
   localparam int CW   = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [XLEN:0]     prem_q, prem_d;        // partial remainder
   logic [XLEN-1:0]   quot_q, quot_d;        // dividend shifting out, quotient shifting in
   logic [XLEN-1:0]   divisor_q, divisor_d;
   logic [XLEN-1:0]   rs1_q, rs1_d;          // raw dividend, remainder of a divide-by-zero
   logic              qsign_q, qsign_d;
   logic              rsign_q, rsign_d;
   logic              rem_q, rem_d;
   logic              div0_q, div0_d;
   logic              ovf_q, ovf_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   tag_q, tag_d;
   logic [31:0]       instr_q, instr_d;
   logic [XLEN-1:0]   out_q, out_d;
   logic [4:0]        out_rd_q, out_rd_d;
   logic [XLEN-1:0]   out_tag_q, out_tag_d;
   logic [31:0]       out_instr_q, out_instr_d;

   logic              accept;
   logic              neg1, neg2;
   logic              in_div0, in_ovf;
   logic [XLEN+1:0]   shifted, trial;
   logic [XLEN-1:0]   q_fix, r_fix, res;

   assign accept  = div_ctrl.legal & div_ctrl.div & ~freeze &
                    ((state_q == IDLE) | (state_q == DONE));
   assign neg1    = ~div_ctrl.unsign & div_ctrl.rs1_data[XLEN-1];
   assign neg2    = ~div_ctrl.unsign & div_ctrl.rs2_data[XLEN-1];
   assign in_div0 = (div_ctrl.rs2_data == '0);
   assign in_ovf  = ~div_ctrl.unsign & (div_ctrl.rs1_data == INT_MIN) &
                    (div_ctrl.rs2_data == '1);

   // prem is always below the divisor, so the shifted value fits in XLEN+1
   // bits and bit XLEN+1 of the difference is a clean borrow flag.
   assign shifted = {prem_q, quot_q[XLEN-1]};
   assign trial   = shifted - {2'b00, divisor_q};

   assign q_fix = qsign_q ? -quot_q : quot_q;
   assign r_fix = rsign_q ? -prem_q[XLEN-1:0] : prem_q[XLEN-1:0];

   always_comb begin
      res = rem_q ? r_fix : q_fix;
      if (div0_q) begin
         res = rem_q ? rs1_q : '1;
      end else if (ovf_q) begin
         res = rem_q ? '0 : INT_MIN;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      prem_d      = prem_q;
      quot_d      = quot_q;
      divisor_d   = divisor_q;
      rs1_d       = rs1_q;
      qsign_d     = qsign_q;
      rsign_d     = rsign_q;
      rem_d       = rem_q;
      div0_d      = div0_q;
      ovf_d       = ovf_q;
      rd_d        = rd_q;
      tag_d       = tag_q;
      instr_d     = instr_q;
      out_d       = out_q;
      out_rd_d    = out_rd_q;
      out_tag_d   = out_tag_q;
      out_instr_d = out_instr_q;

      if (!freeze) begin
         case (state_q)
            CALC: begin
               if (!trial[XLEN+1]) begin
                  prem_d = trial[XLEN:0];
                  quot_d = {quot_q[XLEN-2:0], 1'b1};
               end else begin
                  prem_d = shifted[XLEN:0];
                  quot_d = {quot_q[XLEN-2:0], 1'b0};
               end
               count_d = count_q + 1'b1;
               if (count_q == CW'(XLEN-1)) state_d = FIX;
            end
            FIX: begin
               out_d       = res;
               out_rd_d    = rd_q;
               out_tag_d   = tag_q;
               out_instr_d = instr_q;
               state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
         endcase

         // Accept overrides the IDLE/DONE transitions above.
         if (accept) begin
            divisor_d = neg2 ? -div_ctrl.rs2_data : div_ctrl.rs2_data;
            quot_d    = neg1 ? -div_ctrl.rs1_data : div_ctrl.rs1_data;
            rs1_d     = div_ctrl.rs1_data;
            qsign_d   = neg1 ^ neg2;
            rsign_d   = neg1;
            rem_d     = div_ctrl.rem;
            div0_d    = in_div0;
            ovf_d     = in_ovf;
            rd_d      = div_ctrl.rd_addr;
            tag_d     = div_ctrl.instr_tag;
            instr_d   = div_ctrl.instr;
            prem_d    = '0;
            count_d   = '0;
            state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
            // Result is forced in FIX anyway; one CALC cycle is enough.
            if (in_div0 | in_ovf) count_d = CW'(XLEN-1);
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         count_q     <= '0;
         prem_q      <= '0;
         quot_q      <= '0;
         divisor_q   <= '0;
         rs1_q       <= '0;
         qsign_q     <= 1'b0;
         rsign_q     <= 1'b0;
         rem_q       <= 1'b0;
         div0_q      <= 1'b0;
         ovf_q       <= 1'b0;
         rd_q        <= '0;
         tag_q       <= '0;
         instr_q     <= '0;
         out_q       <= '0;
         out_rd_q    <= '0;
         out_tag_q   <= '0;
         out_instr_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         prem_q      <= prem_d;
         quot_q      <= quot_d;
         divisor_q   <= divisor_d;
         rs1_q       <= rs1_d;
         qsign_q     <= qsign_d;
         rsign_q     <= rsign_d;
         rem_q       <= rem_d;
         div0_q      <= div0_d;
         ovf_q       <= ovf_d;
         rd_q        <= rd_d;
         tag_q       <= tag_d;
         instr_q     <= instr_d;
         out_q       <= out_d;
         out_rd_q    <= out_rd_d;
         out_tag_q   <= out_tag_d;
         out_instr_q <= out_instr_d;
      end
   end

   assign out           = out_q;
   assign out_rd_addr   = out_rd_q;
   assign instr_tag_out = out_tag_q;
   assign instr_out     = out_instr_q;
   assign out_rd_wr_en  = (state_q == DONE);
   assign div_busy      = (state_q == CALC) | (state_q == FIX);
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div : self-checking bench for the iterative divider.
// Driver tasks push the expected writeback (value, rd, tag, instr, cycle) onto
// a queue when an op is issued; an independent monitor pops and compares on
// every new writeback pulse.
// -----------------------------------------------------------------------------
module tb_div;
  localparam int W = 32;
  localparam int EW = W + 5 + W + 32;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic clk = 1'b0;
  logic rstn;
  logic freeze;
  idu1_out_t div_ctrl;
  logic [W-1:0] out;
  logic [4:0] out_rd_addr;
  logic out_rd_wr_en;
  logic [W-1:0] instr_tag_out;
  logic [31:0] instr_out;
  logic div_busy;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  int cyc_q[$];

  div dut (
    .clk(clk), .rstn(rstn), .freeze(freeze), .div_ctrl(div_ctrl),
    .out(out), .out_rd_addr(out_rd_addr), .out_rd_wr_en(out_rd_wr_en),
    .instr_tag_out(instr_tag_out), .instr_out(instr_out),
    .div_busy(div_busy), .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: RISC-V M-extension division rules
  function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    if (b == '0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == '0) return 3;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
`endif
    return W + 2;
  endfunction

  // driver tasks
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int extra, input bit expect_wb);
    logic [4:0] rd;
    logic [W-1:0] tag;
    logic [31:0] ins;
    rd  = 5'($urandom);
    tag = $urandom;
    ins = $urandom;
    div_ctrl.legal     = 1'b1;
    div_ctrl.div       = 1'b1;
    div_ctrl.rem       = op[1];
    div_ctrl.unsign    = op[0];
    div_ctrl.rs1_data  = a;
    div_ctrl.rs2_data  = b;
    div_ctrl.rd_addr   = rd;
    div_ctrl.instr_tag = tag;
    div_ctrl.instr     = ins;
    if (expect_wb) begin
      exp_q.push_back({ref_res(op, a, b), rd, tag, ins});
      cyc_q.push_back(cyc + ref_lat(op, a, b) + extra);
    end
    @(posedge clk); #1;
    div_ctrl.legal = 1'b0;
    div_ctrl.div   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (div_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (div_busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: div_busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // scoreboard monitor: one comparison per new writeback pulse
  logic hold = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int ec;
    if (rstn && out_rd_wr_en && !hold) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: pulse at cycle %0d out=%h, required no writeback", cyc, out);
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        if ({out, out_rd_addr, instr_tag_out, instr_out} !== e || cyc != ec) begin
          fails++;
          $display("FAIL wb: got out=%h rd=%0d tag=%h instr=%h cyc=%0d, required out=%h rd=%0d tag=%h instr=%h cyc=%0d",
                   out, out_rd_addr, instr_tag_out, instr_out, cyc,
                   e[EW-1 -: W], e[W+32+4 -: 5], e[W+31 -: W], e[31:0], ec);
        end
      end
    end
    hold = rstn && out_rd_wr_en && freeze;
  end

  // main stimulus
  initial begin
    int t;
    int n;
    rstn = 1'b0;
    freeze = 1'b0;
    div_ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_wr_en", 32'(out_rd_wr_en), 0);
    check("rst_busy", 32'(div_busy), 0);
    check("rst_rd", 32'(out_rd_addr), 0);
    check("rst_tag", instr_tag_out, 0);
    check("rst_instr", instr_out, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // DIVU 100/7 with busy and pulse profile
    t = cyc;
    issue(OP_DIVU, 100, 7, 0, 1);
    for (int i = 1; i <= W + 2; i++) begin
      check("busy_profile", 32'(div_busy), 32'(i <= W + 1));
      check("wr_en_profile", 32'(out_rd_wr_en), 32'(i == W + 2));
      @(posedge clk); #1;
    end
    check("single_pulse", 32'(out_rd_wr_en), 0);

    // directed arithmetic and special cases, each issued as soon as unit frees
    wait_idle(); issue(OP_REMU, 100, 7, 0, 1);
    wait_idle(); issue(OP_DIV, 32'hFFFF_FFF9, 2, 0, 1);
    wait_idle(); issue(OP_REM, 32'hFFFF_FFF9, 2, 0, 1);
    wait_idle(); issue(OP_REM, 7, 32'hFFFF_FFFE, 0, 1);
    wait_idle(); issue(OP_DIV, 5, 0, 0, 1);
    wait_idle(); issue(OP_REMU, 5, 0, 0, 1);
    wait_idle(); issue(OP_REM, 32'hFFFF_FFFB, 0, 0, 1);
    wait_idle(); issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    wait_idle(); issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);

    // back-to-back: second op issued in the first op's DONE cycle
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    issue(OP_DIVU, 32'h1234_5678, 9, 0, 1);
    repeat (W + 1) @(posedge clk);
    #1;
    check("b2b_done", 32'(out_rd_wr_en), 1);
    issue(OP_DIVU, 32'hFFFF_FFFF, 1, 0, 1);
    // offered while busy: must be dropped
    issue(OP_DIV, 77, 3, 0, 0);

    // freeze for 5 cycles mid-CALC delays the result by 5
    wait_idle();
    issue(OP_DIVU, 1000, 3, 5, 1);
    repeat (8) @(posedge clk);
    #1;
    freeze = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    freeze = 1'b0;

    // freeze during DONE stretches the pulse
    wait_idle();
    t = cyc;
    issue(OP_DIV, 32'hFFFF_FF9C, 9, 0, 1);
    while (cyc < t + W + 2) begin
      @(posedge clk); #1;
    end
    check("done_pulse", 32'(out_rd_wr_en), 1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("done_freeze_hold", 32'(out_rd_wr_en), 1);
    end
    freeze = 1'b0;
    @(posedge clk); #1;
    check("done_freeze_release", 32'(out_rd_wr_en), 0);

    // reset mid-operation aborts without writeback
    wait_idle();
    t = cyc;
    issue(OP_DIVU, 12345, 67, 0, 0);
    while (cyc < t + 10) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_out", out, 0);
    check("abort_wr_en", 32'(out_rd_wr_en), 0);
    check("abort_busy", 32'(div_busy), 0);
    check("abort_tag", instr_tag_out, 0);
    check("abort_instr", instr_out, 0);
    rstn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(OP_REMU, 12345, 67, 0, 1);

    // randomized ops with random gaps
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      a = pick_operand();
      b = pick_operand();
      issue(2'($urandom_range(0, 3)), a, b, 0, 1);
    end

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d writebacks missing, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
